// File: rtl/sram_rd_pkg.sv
// Shared definitions for the SRAM burst reader slice.
//   state_e        : burst FSM states (IDLE, RUN, FIN)
//   DEF_*          : default word width, SRAM depth and output buffer depth
//   addr_w()       : SRAM address width for a given depth
package sram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  localparam int unsigned DEF_DATA_LEN   = 32;
  localparam int unsigned DEF_N_ENTRIES  = 1024;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the reader's output buffer.
//   clk, rst_n : clock, asynchronous active-low reset (flushes pointers/count)
//   push, din  : write din when push is high
//   pop        : drop the head entry when pop is high and not empty
//   dout       : current head entry, read from registered storage
//   count      : occupancy 0..FIFO_DEPTH
//   empty, full: occupancy flags
// FIFO_DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter  int unsigned DATA_LEN   = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_LEN-1:0] din,
  output logic [DATA_LEN-1:0] dout,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full
);

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: reset flushes the pointers, so stale words are never exposed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_chk : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/sram_burst_reader.sv
// Reads a contiguous burst of words from a 1-cycle-latency SRAM and presents
// them as a valid/ready stream with a last flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i, base_i     : burst request and first address (sampled when idle)
//   len_i               : word count 0..N_ENTRIES
//   busy_o, done_o      : burst in progress / one-cycle completion pulse
//   sram_en_o           : SRAM read enable; sram_addr_o : SRAM address
//   sram_data_i         : SRAM read data, valid the cycle after sram_en_o
//   m_valid_o, m_data_o, m_last_o, m_ready_i : output stream
module sram_burst_reader
  import sram_rd_pkg::*;
#(
  parameter  int unsigned DATA_LEN   = DEF_DATA_LEN,
  parameter  int unsigned N_ENTRIES  = DEF_N_ENTRIES,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned ADDR_W     = addr_w(N_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [ADDR_W:0]     len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                sram_en_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  input  logic [DATA_LEN-1:0] sram_data_i,
  output logic                m_valid_o,
  output logic [DATA_LEN-1:0] m_data_o,
  output logic                m_last_o,
  input  logic                m_ready_i
);

  localparam int unsigned    CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] ISSUE_LIMIT = (CNT_W + 1)'(FIFO_DEPTH - 2);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(N_ENTRIES - 1);

  state_e              state;
  state_e              state_nx;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     issue_rem;
  logic [ADDR_W:0]     beats_rem;
  logic                pend_q;
  logic                issue;
  logic                valid;
  logic                last;
  logic                beat_taken;
  logic                take_start;
  logic [CNT_W:0]      inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DATA_LEN-1:0] fifo_head;

  sync_fifo #(
    .DATA_LEN   (DATA_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend_q),
    .pop   (beat_taken),
    .din   (sram_data_i),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Words already buffered plus the read still in the SRAM pipe. Issue only
  // while this leaves room for one more, ignoring any pop in the same cycle.
  assign inflight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};

  always_comb begin
    state_nx   = state;
    take_start = (state == IDLE) && start_i;
    issue      = (state == RUN) && (issue_rem != '0) && (inflight <= ISSUE_LIMIT);
    valid      = (state == RUN) && !fifo_empty;
    last       = valid && (beats_rem == (ADDR_W + 1)'(1));
    beat_taken = valid && m_ready_i;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = (len_i == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (beat_taken && last) begin
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      issue_rem <= '0;
      beats_rem <= '0;
      pend_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      pend_q <= issue;
      if (take_start) begin
        rd_addr   <= base_i;
        issue_rem <= len_i;
        beats_rem <= len_i;
      end else begin
        if (issue) begin
          rd_addr   <= (rd_addr == TOP_ADDR) ? '0 : rd_addr + ADDR_W'(1);
          issue_rem <= issue_rem - (ADDR_W + 1)'(1);
        end
        if (beat_taken) begin
          beats_rem <= beats_rem - (ADDR_W + 1)'(1);
        end
      end
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == FIN);
  assign sram_en_o   = issue;
  assign sram_addr_o = rd_addr;
  assign m_valid_o   = valid;
  assign m_last_o    = last;
  assign m_data_o    = valid ? fifo_head : '0;

  no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                 !(pend_q && fifo_full && !beat_taken));

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned NE = 1024;
  localparam int unsigned AW = 10;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic          sram_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;

  logic [DW-1:0] mem [NE];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // SRAM read port with one cycle of latency.
  always @(posedge clk) begin
    if (sram_en) sram_data <= mem[sram_addr];
  end

  sram_burst_reader #(
    .DATA_LEN   (DW),
    .N_ENTRIES  (NE),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_i      (base),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .sram_en_o   (sram_en),
    .sram_addr_o (sram_addr),
    .sram_data_i (sram_data),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .m_last_o    (m_last),
    .m_ready_i   (m_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input bit with_addr);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_en"}, sram_en, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_last"}, m_last, 0);
    if (with_addr) check({tag, "_addr"}, sram_addr, 0);
  endtask

  // One burst: start in cycle 0, then observe every cycle until done_o.
  // Expected data comes from the memory contents at base+k mod depth.
  task automatic run_burst(input int b, input int l, input bit rnd_ready,
                           input bit timing, input int restart_at);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] stall_data = '0;
    int issued = 0;
    int taken = 0;
    int dones = 0;
    int first_en = -1;
    int first_valid = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    int cyc = 0;
    bit stalled = 0;
    for (int k = 0; k < l; k++) exp_q.push_back(mem[(b + k) % NE]);
    @(negedge clk);
    start = 1'b1;
    base = AW'(b);
    len = (AW + 1)'(l);
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < l * 6 + 20) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (start) begin
        base = AW'(500);
        len = (AW + 1)'(9);
      end
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check("busy_in_burst", busy, 1);
      if (sram_en) begin
        if (first_en < 0) first_en = cyc;
        check("issue_addr", sram_addr, (b + issued) % NE);
        issued++;
      end
      check("inflight_bound", (issued - taken) <= FD, 1);
      if (stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
      end
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (taken < l) begin
          check("beat_data", m_data, exp_q[taken]);
          check("beat_last", m_last, taken == l - 1);
        end else begin
          check("extra_beat", taken, l - 1);
        end
        if (m_ready) begin
          if (taken == l - 1) last_cyc = cyc;
          taken++;
        end
        stalled = !m_ready;
        stall_data = m_data;
      end else begin
        stalled = 0;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", dones, 1);
    check("beat_count", taken, l);
    check("issue_count", issued, l);
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_valid", m_valid, 0);
    check("post_en", sram_en, 0);
    if (restart_at > 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("restart_no_busy", busy, 0);
        check("restart_no_done", done, 0);
      end
    end
    if (timing) begin
      if (l > 0) begin
        check("first_en_cycle", first_en, 1);
        check("first_valid_cycle", first_valid, 3);
        check("last_beat_cycle", last_cyc, l + 2);
        check("done_cycle", done_cyc, l + 3);
      end else begin
        check("len0_no_en", first_en, -1);
        check("len0_no_valid", first_valid, -1);
        check("len0_done_cycle", done_cyc, 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) mem[i] = DW'(i);

    // Reset state, during and after reset.
    #1;
    check_quiet("in_reset", 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset", 1);

    // Basic burst, then a burst that wraps past the top entry.
    run_burst(5, 4, 0, 1, -1);
    run_burst(1022, 4, 0, 1, -1);

    // Random backpressure.
    run_burst(0, 16, 1, 0, -1);

    // Zero-length request.
    run_burst(7, 0, 0, 1, -1);

    // Asynchronous reset in cycle 4 of a len=8 burst.
    @(negedge clk);
    start = 1'b1;
    base = '0;
    len = (AW + 1)'(8);
    m_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("pre_reset_done", done, 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet("mid_burst_reset", 1);
    @(negedge clk);
    check_quiet("reset_hold", 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset_release", 1);
    run_burst(0, 2, 0, 1, -1);

    // Second start during a burst is ignored.
    run_burst(10, 4, 0, 1, 2);

    // Every entry once, wrapping from base 300.
    run_burst(300, 1024, 0, 1, -1);

    // Random contents, bases, lengths and backpressure.
    for (int i = 0; i < NE; i++) mem[i] = $urandom;
    for (int t = 0; t < 6; t++) begin
      run_burst(int'($urandom_range(0, NE - 1)), int'($urandom_range(1, 40)), 1, 0, -1);
    end
    run_burst(1015, 20, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
